// File: rtl/div_rebuild.sv
`default_nettype none
// ============================================================================
// Module      : div_rebuild
// Description : N-stage shift-add pipeline that rebuilds a dividend from
//               quotient, divisor and remainder, and checks it against a reference.
// Revision    : 1.0 - initial release
// ============================================================================
module div_rebuild #(
    parameter int N = 5,
    parameter int M = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         data_rdy,
    input  logic [N-1:0] merchant,
    input  logic [M-1:0] divisor,
    input  logic [N-1:0] remainder,
    input  logic [N-1:0] dividend_ref,
    output logic         rdy,
    output logic [N+M-1:0] dividend,
    output logic         err
);

    localparam int W = N + M;

    logic [N-1:0] vld_q, vld_d;
    logic [W-1:0] acc_q [N];
    logic [W-1:0] acc_d [N];
    // Operand copies travel with each stage so that stages never read live inputs
    logic [N-1:0] m_q   [N-1];
    logic [N-1:0] m_d   [N-1];
    logic [M-1:0] dv_q  [N-1];
    logic [M-1:0] dv_d  [N-1];
    logic [N-1:0] ref_q [N-1];
    logic [N-1:0] ref_d [N-1];
    logic         bad_q [N-1];
    logic         bad_d [N-1];
    logic         err_q, err_d;

    for (genvar k = 0; k < N; k++) begin : g_stage
        logic         in_vld;
        logic         in_mbit;
        logic         in_bad;
        logic [W-1:0] in_acc;
        logic [W-1:0] sum;
        logic [M-1:0] in_dv;
        logic [N-1:0] in_ref;

        if (k == 0) begin : g_first
            assign in_vld  = data_rdy;
            assign in_mbit = merchant[0];
            assign in_acc  = {{M{1'b0}}, remainder};
            assign in_dv   = divisor;
            assign in_ref  = dividend_ref;
            assign in_bad  = ({{M{1'b0}}, remainder} >= {{N{1'b0}}, divisor});
            assign m_d[0]  = data_rdy ? merchant : m_q[0];
        end else begin : g_next
            assign in_vld  = vld_q[k-1];
            assign in_mbit = m_q[k-1][k];
            assign in_acc  = acc_q[k-1];
            assign in_dv   = dv_q[k-1];
            assign in_ref  = ref_q[k-1];
            assign in_bad  = bad_q[k-1];
            if (k < N - 1) begin : g_mid
                assign m_d[k] = in_vld ? m_q[k-1] : m_q[k];
            end
        end

        assign sum       = in_acc + (in_mbit ? ({{N{1'b0}}, in_dv} << k) : '0);
        assign vld_d[k]  = in_vld;
        assign acc_d[k]  = in_vld ? sum : acc_q[k];

        if (k < N - 1) begin : g_carry
            assign dv_d[k]  = in_vld ? in_dv  : dv_q[k];
            assign ref_d[k] = in_vld ? in_ref : ref_q[k];
            assign bad_d[k] = in_vld ? in_bad : bad_q[k];
        end else begin : g_last
            // Overflow into the upper M bits means the reference can never match
            assign err_d = in_vld ? (in_bad || (|sum[W-1:N]) || (sum[N-1:0] != in_ref))
                                  : err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                acc_q[i] <= '0;
            end
            for (int i = 0; i < N - 1; i++) begin
                m_q[i]   <= '0;
                dv_q[i]  <= '0;
                ref_q[i] <= '0;
                bad_q[i] <= 1'b0;
            end
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            acc_q <= acc_d;
            m_q   <= m_d;
            dv_q  <= dv_d;
            ref_q <= ref_d;
            bad_q <= bad_d;
        end
    end

    assign rdy      = vld_q[N-1];
    assign dividend = acc_q[N-1];
    assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_div_rebuild.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_rebuild
// Description : Scoreboard bench for div_rebuild using hand-computed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_rebuild;

    localparam int N = 5;
    localparam int M = 3;
    localparam int W = N + M;

    typedef struct {
        int           cyc;
        logic [W-1:0] div;
        logic         err;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         data_rdy;
    logic [N-1:0] merchant;
    logic [M-1:0] divisor;
    logic [N-1:0] remainder;
    logic [N-1:0] dividend_ref;
    logic         rdy;
    logic [W-1:0] dividend;
    logic         err;

    exp_t         sb_q[$];
    int           cyc;
    int           n_tests;
    int           n_fail;
    bit           mon_en;
    logic [W-1:0] last_div;
    logic         last_err;

    div_rebuild #(.N(N), .M(M)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .data_rdy     (data_rdy),
        .merchant     (merchant),
        .divisor      (divisor),
        .remainder    (remainder),
        .dividend_ref (dividend_ref),
        .rdy          (rdy),
        .dividend     (dividend),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: pops on every rdy pulse, otherwise checks that outputs hold
    always @(negedge clk) begin
        if (mon_en) begin
            if (rdy === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rdy", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("rdy_cycle", cyc, e.cyc);
                    check("dividend", int'(dividend), int'(e.div));
                    check("err", int'(err), int'(e.err));
                    last_div = e.div;
                    last_err = e.err;
                end
            end else begin
                check("rdy_low", int'(rdy), 0);
                check("hold_dividend", int'(dividend), int'(last_div));
                check("hold_err", int'(err), int'(last_err));
            end
        end
    end

    task automatic issue(input logic [N-1:0] m, input logic [M-1:0] d, input logic [N-1:0] r,
                         input logic [N-1:0] ref_v, input logic [W-1:0] exp_div, input logic exp_err);
        exp_t e;
        @(posedge clk);
        #1;
        data_rdy     = 1'b1;
        merchant     = m;
        divisor      = d;
        remainder    = r;
        dividend_ref = ref_v;
        e.cyc = cyc + N;
        e.div = exp_div;
        e.err = exp_err;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            data_rdy = 1'b0;
            merchant = $urandom_range(0, 31);
        end
    endtask

    // One-cycle reset: in-flight operands are dropped from the scoreboard
    task automatic pulse_reset();
        @(posedge clk);
        #1;
        data_rdy = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        sb_q.delete();
        last_div = '0;
        last_err = 1'b0;
        rst      = 1'b0;
        data_rdy = 1'b0;
    endtask

    initial begin
        cyc          = 0;
        n_tests      = 0;
        n_fail       = 0;
        mon_en       = 1'b0;
        last_div     = '0;
        last_err     = 1'b0;
        rst          = 1'b1;
        data_rdy     = 1'b1;
        merchant     = '0;
        divisor      = '0;
        remainder    = '0;
        dividend_ref = '0;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        data_rdy = 1'b0;
        mon_en   = 1'b1;
        idle(3);

        // Single operation
        issue(5'd4, 3'd7, 5'd3, 5'd31, 8'd31, 1'b0);
        idle(8);
        // Maximum operands
        issue(5'd31, 3'd7, 5'd31, 5'd31, 8'hF8, 1'b1);
        idle(8);
        // Back-to-back with a bubble
        issue(5'd4, 3'd7, 5'd3, 5'd31, 8'd31, 1'b0);
        issue(5'd2, 3'd5, 5'd1, 5'd11, 8'd11, 1'b0);
        idle(1);
        issue(5'd0, 3'd3, 5'd2, 5'd2, 8'd2, 1'b0);
        idle(8);
        // Reference mismatch
        issue(5'd3, 3'd4, 5'd1, 5'd12, 8'd13, 1'b1);
        idle(8);
        // Divisor zero
        issue(5'd9, 3'd0, 5'd5, 5'd5, 8'd5, 1'b1);
        idle(8);
        // Reset mid-flight
        issue(5'd6, 3'd5, 5'd4, 5'd2, 8'd34, 1'b1);
        issue(5'd1, 3'd6, 5'd0, 5'd6, 8'd6, 1'b0);
        pulse_reset();
        issue(5'd5, 3'd6, 5'd2, 5'd0, 8'd32, 1'b1);
        idle(1);

        for (int i = 0; i < 40 && sb_q.size() != 0; i++) begin
            @(posedge clk);
        end
        idle(3);
        check("scoreboard_drained", sb_q.size(), 0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_rebuild.md
DIV_REBUILD -- requirements
Module: div_rebuild

Interface
REQ-001 SHALL have parameter N, default 5: width of merchant, remainder and dividend_ref.
REQ-002 SHALL have parameter M, default 3: width of divisor.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port data_rdy, input, 1: operand set valid this cycle.
REQ-006 SHALL have port merchant, input, N: quotient to rebuild from.
REQ-007 SHALL have port divisor, input, M: divisor.
REQ-008 SHALL have port remainder, input, N: remainder.
REQ-009 SHALL have port dividend_ref, input, N: expected dividend for self-check.
REQ-010 SHALL have port rdy, output, 1: result valid, one-cycle pulse per operand set.
REQ-011 SHALL have port dividend, output, N+M: merchant*divisor + remainder.
REQ-012 SHALL have port err, output, 1: self-check failure, valid when rdy=1.

Function
REQ-013 SHALL compute dividend = merchant*divisor + remainder, unsigned, with no truncation.
- Maximum value is (2^N-1)*2^M, which fits in N+M bits.
REQ-014 SHALL be an N-stage shift-add pipeline.
- Stage k (k=0..N-1) adds (divisor << k) when merchant bit k is 1, else adds 0.
- The accumulator is seeded with remainder, zero-extended to N+M bits, at stage 0.
REQ-015 SHALL carry merchant, divisor and dividend_ref registered alongside each stage.
- Every stage uses only its own registered copies, never the live inputs.
REQ-016 SHALL sample operands at the rising edge where data_rdy=1.
- rdy=1 with the matching result exactly N edges later (latency N cycles).
REQ-017 SHALL accept a new operand set every cycle (throughput 1/cycle).
- No back-pressure.
- Results emerge in input order.
REQ-018 SHALL propagate a per-stage valid bit.
- A data_rdy=0 cycle becomes a bubble, producing rdy=0 exactly N cycles later.
REQ-019 SHALL update a stage's data registers only when that stage's incoming valid is 1.
- Otherwise the stage holds its data.
- dividend/err therefore hold the last valid result while rdy=0.
REQ-020 SHALL set err=1 when either check fails:
- dividend[N+M-1:N] is not all zero, or dividend[N-1:0] != dividend_ref;
- remainder >= divisor, using the stage-carried copies.
- Otherwise err=0.
REQ-021 SHALL treat divisor=0 as legal arithmetic (dividend = remainder).
- err=1 in this case per REQ-020.
REQ-022 SHALL register err together with dividend, so both become valid on the same rdy cycle.
REQ-023 SHALL, when data_rdy is X-free and held at 0, keep rdy=0 indefinitely.

Reset
REQ-024 SHALL, while rst=1 at a rising edge, clear every stage valid bit and all data registers to 0.
REQ-025 SHALL drive rdy=0, dividend=0, err=0 from the first edge with rst=1 until new results arrive.
REQ-026 SHALL discard in-flight operands when rst is asserted mid-operation.
- No rdy pulse is produced for operands accepted before reset.
REQ-027 SHALL ignore data_rdy on any edge where rst=1.
- The first accepted operand is the one sampled on the first edge with rst=0.

Verification
REQ-028 Single op (N=5, M=3): merchant=4, divisor=7, remainder=3, dividend_ref=31, data_rdy pulsed one cycle.
- Required: rdy=1 exactly 5 cycles later with dividend=31, err=0.
- rdy=0 on all other cycles.
REQ-029 Max operands: merchant=31, divisor=7, remainder=31.
- Required: dividend=248 (8'hF8).
- err=1, from nonzero upper bits and remainder>=divisor.
REQ-030 Back-to-back with bubble: three sets on cycles t, t+1, t+3.
- Sets: (4,7,3,ref 31), (2,5,1,ref 11), (0,3,2,ref 2).
- Required: rdy on cycles t+5, t+6, t+8 with dividend 31, 11, 2 and err 0, 0, 0.
- rdy=0 at t+7, with dividend holding 11.
REQ-031 Self-check miss: merchant=3, divisor=4, remainder=1, dividend_ref=12.
- Required: dividend=13, err=1.
REQ-032 Divisor zero: merchant=9, divisor=0, remainder=5, dividend_ref=5.
- Required: dividend=5, err=1.
REQ-033 Reset mid-flight: operands accepted at t and t+1; rst=1 for one cycle at t+2; new set at t+4.
- Required: no rdy for the first two sets.
- Outputs read 0 from the reset edge onward.
- Single rdy at t+9 for the new set.
